// File: rtl/lasd_pkg.sv
// Shared types and constants for the board stopwatch: FSM state encoding and BCD digit limits.
package lasd_pkg;

  typedef enum logic [1:0] {
    SW_IDLE  = 2'd0,
    SW_RUN   = 2'd1,
    SW_PAUSE = 2'd2
  } sw_state_t;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] CS_MAX       = 4'd9;
  localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch control bundle: raw button levels in, BCD display / status out, plus FSM state for debug.
interface stopwatch_ctrl_if;
  import lasd_pkg::*;

  // No valid/ready pairing here: buttons are free-running levels sampled every clock,
  // and every output is valid on every cycle once reset has been released.
  logic                 start_stop;
  logic                 clear;
  logic                 lap;
  logic [4*BCD_W-1:0]   bcd_out;
  logic                 running;
  logic                 wrap;
  sw_state_t            state;

  modport master (output start_stop, clear, lap,
                  input  bcd_out, running, wrap, state);
  modport slave  (input  start_stop, clear, lap,
                  output bcd_out, running, wrap, state);

endinterface

// File: rtl/bcd_digit.sv
// One BCD counter digit that rolls over at MAX and reports a carry on the rollover increment.
module bcd_digit
  import lasd_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = CS_MAX
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  assign carry = inc & (q == MAX);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= (q == MAX) ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: IDLE/RUN/PAUSE FSM gating a prescaler that drives an SS.cc BCD chain.
// Optional lap-hold display freeze is built when LAP_HOLD_EN is defined.
module stopwatch_ctrl
  import lasd_pkg::*;
#(
  parameter int TICK_DIV = 500_000
) (
  input  logic              clock,
  input  logic              rst,
  stopwatch_ctrl_if.slave   sw
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

`ifdef LAP_HOLD_EN
  localparam int NBTN = 3;
`else
  localparam int NBTN = 2;
`endif

  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] btn_edge;

`ifdef LAP_HOLD_EN
  assign btn_raw = {sw.lap, sw.clear, sw.start_stop};
`else
  logic unused_lap;
  assign unused_lap = sw.lap;
  assign btn_raw    = {sw.clear, sw.start_stop};
`endif

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    logic s1, s2, prev;
    always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
        s1   <= 1'b0;
        s2   <= 1'b0;
        prev <= 1'b0;
      end else begin
        s1   <= btn_raw[i];
        s2   <= s1;
        prev <= s2;
      end
    end
    assign btn_edge[i] = s2 & ~prev;
  end

  logic start_e, clear_e;
  assign start_e = btn_edge[0];
  assign clear_e = btn_edge[1];

  sw_state_t state, state_next;
  logic      running_q;
  logic      count_en;
  logic      cnt_clr;

  // running is derived from the same next-state value so it never lags the state register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state     <= SW_IDLE;
      running_q <= 1'b0;
    end else begin
      state     <= state_next;
      running_q <= (state_next == SW_RUN);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SW_IDLE:  if (start_e) state_next = SW_RUN;
      SW_RUN:   if (start_e) state_next = SW_PAUSE;
      SW_PAUSE: begin
        if (clear_e)      state_next = SW_IDLE;
        else if (start_e) state_next = SW_RUN;
      end
      default:  state_next = SW_IDLE;
    endcase
  end

  always_comb begin
    count_en = (state == SW_RUN);
    cnt_clr  = (state == SW_PAUSE) & clear_e;
  end

  logic [PW-1:0] presc;
  logic          tick;

  // The prescaler only moves in RUN, so a pause keeps the partial tick for the resume.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (cnt_clr) begin
      presc <= '0;
    end else if (count_en) begin
      presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
    end
  end

  assign tick = count_en & (presc == PRE_LAST);

  logic [BCD_W-1:0] digit [4];
  logic [4:0]       cy;
  logic [15:0]      live;
  logic             wrap_q;

  assign cy[0] = tick;

  for (genvar i = 0; i < 4; i++) begin : g_digit
    bcd_digit #(.MAX((i == 3) ? SEC_TENS_MAX : CS_MAX)) u_digit (
      .clock (clock),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (cy[i]),
      .q     (digit[i]),
      .carry (cy[i+1])
    );
  end

  assign live = {digit[3], digit[2], digit[1], digit[0]};

  always_ff @(posedge clock or posedge rst) begin
    if (rst) wrap_q <= 1'b0;
    else     wrap_q <= cy[4];
  end

`ifdef LAP_HOLD_EN
  logic        frozen;
  logic [15:0] snap;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      frozen <= 1'b0;
      snap   <= '0;
    end else if (state_next == SW_IDLE) begin
      frozen <= 1'b0;
    end else if (count_en & btn_edge[2]) begin
      frozen <= ~frozen;
      snap   <= live;
    end
  end

  assign sw.bcd_out = frozen ? snap : live;
`else
  assign sw.bcd_out = live;
`endif

  assign sw.running = running_q;
  assign sw.wrap    = wrap_q;
  assign sw.state   = state;

endmodule
